// File: rtl/glyph_matcher_pkg.sv
// Shared constants and types for the glyph matcher and its interface.
// Rows use [0:W-1] ordering so bit 0 is the leftmost pixel.
package glyph_matcher_pkg;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;
  localparam int ADDR_W  = 4;
  localparam int DIST_W  = 9;
  localparam int CNT_W   = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  typedef logic [0:GLYPH_W-1] glyph_row_t;

  function automatic logic is_last_row(input logic [ADDR_W-1:0] addr);
    return addr == ADDR_W'(GLYPH_H - 1);
  endfunction

endpackage

// File: rtl/glyph_matcher_if.sv
// Bitmap-write, scan-control, template-ROM and result signals of the glyph matcher.
// start/pix_we/clear are sampled only while busy is low; done pulses one cycle when distance/match update.
interface glyph_matcher_if;
  import glyph_matcher_pkg::*;

  logic              pix_we;
  logic [ADDR_W-1:0] pix_x;
  logic [ADDR_W-1:0] pix_y;
  logic              pix_val;
  logic              clear;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  glyph_row_t        rom_row;
  logic              busy;
  logic              done;
  logic [DIST_W-1:0] distance;
  logic              match;

  modport master (
    output pix_we, pix_x, pix_y, pix_val, clear, start, rom_row,
    input  rom_addr, busy, done, distance, match
  );

  modport slave (
    input  pix_we, pix_x, pix_y, pix_val, clear, start, rom_row,
    output rom_addr, busy, done, distance, match
  );

endinterface

// File: rtl/glyph_matcher_popcount16.sv
// Combinational population count of a 16-bit vector, built as a balanced adder tree.
module popcount16 (
  input  logic [15:0] i_vec,
  output logic [4:0]  o_cnt
);

  logic [1:0] w_l1 [8];
  logic [2:0] w_l2 [4];
  logic [3:0] w_l3 [2];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_l1[i] = {1'b0, i_vec[2*i]} + {1'b0, i_vec[2*i+1]};
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_l2[i] = {1'b0, w_l1[2*i]} + {1'b0, w_l1[2*i+1]};
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_l3[i] = {1'b0, w_l2[2*i]} + {1'b0, w_l2[2*i+1]};
    end
  end

  assign o_cnt = {1'b0, w_l3[0]} + {1'b0, w_l3[1]};

endmodule

// File: rtl/glyph_matcher.sv
// Holds a 16x16 drawn bitmap and scans a template ROM row by row, accumulating the
// Hamming distance and reporting distance/match through a start/busy/done handshake.
module glyph_matcher
  import glyph_matcher_pkg::*;
#(
  parameter int unsigned THRESHOLD = 24
) (
  input  logic  clk,
  input  logic  rst_n,
  glyph_matcher_if.slave bus,
  output state_t o_dbg_state
);

  state_t            r_state;
  glyph_row_t        r_bitmap [GLYPH_H];
  logic [ADDR_W-1:0] r_rom_addr;
  logic [DIST_W-1:0] r_acc;
  logic [DIST_W-1:0] r_distance;
  logic              r_busy;
  logic              r_done;
  logic              r_match;

  glyph_row_t        w_diff;
  logic [CNT_W-1:0]  w_cnt;
  logic [DIST_W-1:0] w_sum;
  logic              w_within;

  // The ROM answers in the same cycle, so the current row is compared straight away.
  assign w_diff = r_bitmap[r_rom_addr] ^ bus.rom_row;

  popcount16 u_popcount (
    .i_vec (w_diff),
    .o_cnt (w_cnt)
  );

  assign w_sum    = r_acc + DIST_W'(w_cnt);
  assign w_within = (32'(w_sum) <= THRESHOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rom_addr <= '0;
      r_acc      <= '0;
      r_distance <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= 1'b0;
      for (int y = 0; y < GLYPH_H; y++) begin
        r_bitmap[y] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Clear has priority over a simultaneous pixel write.
          if (bus.clear) begin
            for (int y = 0; y < GLYPH_H; y++) begin
              r_bitmap[y] <= '0;
            end
          end else if (bus.pix_we) begin
            r_bitmap[bus.pix_y][bus.pix_x] <= bus.pix_val;
          end
          if (bus.start) begin
            r_state    <= ST_SCAN;
            r_rom_addr <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_SCAN: begin
          r_acc <= w_sum;
          if (is_last_row(r_rom_addr)) begin
            r_distance <= w_sum;
            r_match    <= w_within;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_rom_addr <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_rom_addr <= r_rom_addr + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr = r_rom_addr;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.distance = r_distance;
  assign bus.match    = r_match;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_glyph_matcher.sv
// Randomised bench for glyph_matcher against a '+' template ROM, with a pixel-level
// reference model feeding an expected-result queue consumed by a done-driven monitor.
module tb_glyph_matcher;
  import glyph_matcher_pkg::*;

  localparam int THR = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  glyph_matcher_if gm();
  state_t dbg_state;

  glyph_matcher #(.THRESHOLD(THR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (gm),
    .o_dbg_state (dbg_state)
  );

  function automatic bit is_plus(input int x, input int y);
    return ((y >= 6) && (y <= 8)) || ((x >= 6) && (x <= 8));
  endfunction

  always_comb begin
    gm.rom_row = '0;
    for (int x = 0; x < 16; x++) begin
      gm.rom_row[x] = is_plus(x, int'(gm.rom_addr));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  bit          m_bmp [16][16];
  int          m_scan_start = -100;
  int          m_scan_end   = -1;
  logic [8:0]  m_last_dist  = '0;
  logic        m_last_match = 1'b0;
  logic [41:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_dist();
    int d = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if (m_bmp[y][x] != is_plus(x, y)) d++;
    return d;
  endfunction

  function automatic void model_clear();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        m_bmp[y][x] = 1'b0;
  endfunction

  // Drives one cycle of inputs (called #1 after a rising edge) and updates the model.
  task automatic drive_cycle(input bit we, input int x, input int y, input bit v,
                             input bit clr, input bit st);
    int e;
    int d;
    bit idle;
    e    = cyc + 1;
    idle = (e > m_scan_end);
    gm.pix_we  = we;
    gm.pix_x   = 4'(x);
    gm.pix_y   = 4'(y);
    gm.pix_val = v;
    gm.clear   = clr;
    gm.start   = st;
    if (idle) begin
      if (clr) model_clear();
      else if (we) m_bmp[y][x] = v;
      if (st) begin
        d = model_dist();
        exp_q.push_back({32'(e + 16), (d <= THR), 9'(d)});
        m_scan_start = e;
        m_scan_end   = e + 16;
      end
    end
    @(posedge clk);
    #1;
    gm.pix_we = 1'b0;
    gm.clear  = 1'b0;
    gm.start  = 1'b0;
  endtask

  task automatic nop();
    drive_cycle(0, 0, 0, 0, 0, 0);
  endtask

  // Returns #1 after the edge that raises done, i.e. inside the done cycle.
  task automatic wait_idle();
    while (cyc + 1 <= m_scan_end) nop();
  endtask

  task automatic write_plus();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if (is_plus(x, y)) drive_cycle(1, x, y, 1, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    m_scan_start = -100;
    m_scan_end   = -1;
    m_last_dist  = '0;
    m_last_match = 1'b0;
    #1;
    chk("reset_busy", int'(gm.busy), 0);
    chk("reset_done", int'(gm.done), 0);
    chk("reset_distance", int'(gm.distance), 0);
    chk("reset_match", int'(gm.match), 0);
    chk("reset_rom_addr", int'(gm.rom_addr), 0);
    chk("reset_state", int'(dbg_state), int'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    bit          in_scan;
    logic [41:0] ent;
    if (rst_n) begin
      in_scan = (cyc >= m_scan_start) && (cyc < m_scan_start + 16);
      chk("busy", int'(gm.busy), int'(in_scan));
      chk("rom_addr", int'(gm.rom_addr), in_scan ? cyc - m_scan_start : 0);
      if (gm.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ent = exp_q.pop_front();
          chk("done_cycle", cyc, int'(ent[41:10]));
          chk("distance", int'(gm.distance), int'(ent[8:0]));
          chk("match", int'(gm.match), int'(ent[9]));
          m_last_dist  = ent[8:0];
          m_last_match = ent[9];
        end
      end else begin
        chk("distance_hold", int'(gm.distance), int'(m_last_dist));
        chk("match_hold", int'(gm.match), int'(m_last_match));
        if (exp_q.size() != 0 && cyc >= int'(exp_q[0][41:10])) begin
          chk("missing_done", 0, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int idx [256];
    int t;
    int j;
    gm.pix_we = 1'b0; gm.pix_x = '0; gm.pix_y = '0; gm.pix_val = 1'b0;
    gm.clear = 1'b0; gm.start = 1'b0;
    #2;
    do_reset();

    // Exact '+' drawn pixel by pixel.
    write_plus();
    drive_cycle(0, 0, 0, 0, 0, 1);
    wait_idle();
    chk("s1_distance", int'(gm.distance), 0);
    chk("s1_match", int'(gm.match), 1);

    // Empty bitmap.
    do_reset();
    drive_cycle(0, 0, 0, 0, 0, 1);
    wait_idle();
    chk("s2_distance", int'(gm.distance), 87);
    chk("s2_match", int'(gm.match), 0);

    // Full bitmap.
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) drive_cycle(1, x, y, 1, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1);
    wait_idle();
    chk("s3_distance", int'(gm.distance), 169);
    chk("s3_match", int'(gm.match), 0);

    // Threshold boundary: 24 then 25 randomly chosen flipped pixels.
    do_reset();
    write_plus();
    for (int i = 0; i < 256; i++) idx[i] = i;
    for (int i = 0; i < 25; i++) begin
      j = $urandom_range(255, i);
      t = idx[i]; idx[i] = idx[j]; idx[j] = t;
    end
    for (int i = 0; i < 24; i++)
      drive_cycle(1, idx[i] % 16, idx[i] / 16, !is_plus(idx[i] % 16, idx[i] / 16), 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1);
    wait_idle();
    chk("s4_distance_24", int'(gm.distance), 24);
    chk("s4_match_24", int'(gm.match), 1);
    drive_cycle(1, idx[24] % 16, idx[24] / 16, !is_plus(idx[24] % 16, idx[24] / 16), 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1);
    wait_idle();
    chk("s4_distance_25", int'(gm.distance), 25);
    chk("s4_match_25", int'(gm.match), 0);

    // Inputs during a scan are ignored; back-to-back rescan confirms pixel (0,0) untouched.
    do_reset();
    write_plus();
    drive_cycle(0, 0, 0, 0, 0, 1);
    repeat (3) drive_cycle(1, 0, 0, 1, 1, 1);
    wait_idle();
    chk("s5_distance", int'(gm.distance), 0);
    chk("s5_match", int'(gm.match), 1);
    drive_cycle(0, 0, 0, 0, 0, 1);
    wait_idle();
    chk("s5_rescan_distance", int'(gm.distance), 0);

    // Reset in the middle of a scan.
    drive_cycle(0, 0, 0, 0, 0, 1);
    repeat (8) nop();
    do_reset();
    drive_cycle(0, 0, 0, 0, 0, 1);
    wait_idle();
    chk("s6_distance", int'(gm.distance), 87);
    chk("s6_match", int'(gm.match), 0);

    // Random writes, clears and control traffic, including inputs during scans.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 4) == 0) write_plus();
      repeat ($urandom_range(0, 24))
        drive_cycle(1, $urandom_range(0, 15), $urandom_range(0, 15),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), 0);
      drive_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 1);
      repeat ($urandom_range(0, 20))
        drive_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end

    wait_idle();
    repeat (20) nop();
    chk("pending_results", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/glyph_matcher.md
Name: glyph_matcher

Overview:
Sequential consumer of a 16x16 glyph template ROM, such as the operator and digit character ROMs in the recognition path. It holds a user-drawn 16x16 bitmap written pixel by pixel, scans the template ROM row by row, and accumulates the Hamming distance between the drawing and the template. It reports the distance and a threshold match flag to the recognition and display control logic through a start/busy/done handshake.

Parameters:
THRESHOLD, 24, maximum distance (inclusive) that still asserts match; legal range 0..256.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
pix_we  input  1  pixel write strobe; sampled only in IDLE
pix_x  input  4  pixel column; 0 is the leftmost pixel
pix_y  input  4  pixel row; 0 is the top row
pix_val  input  1  value written to pixel (pix_x, pix_y)
clear  input  1  zero the whole bitmap in one cycle; sampled only in IDLE
start  input  1  begin a scan; sampled only in IDLE
rom_addr  output  4  template row address driven to the glyph ROM
rom_row  input  [0:15]  template row returned combinationally by the ROM; bit 0 is the leftmost pixel
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when distance and match become valid
distance  output  9  Hamming distance, 0..256
match  output  1  high when distance <= THRESHOLD

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; bitmap all 0; accumulator 0.
  - rom_addr = 0, busy = 0, done = 0, distance = 0, match = 0.
  - Reset asserted mid-scan aborts the scan immediately; no done pulse is produced.
- Bitmap storage: 16 rows x 16 bits, stored row[y][x], with x = 0 at bit index 0, the same orientation as rom_row.
- ROM interface: rom_addr is a registered output. The ROM is combinational, with zero latency: rom_row is sampled on the same edge that sees the matching rom_addr.
- State IDLE:
  - clear = 1: all 256 bits cleared at the edge. If pix_we is high in the same cycle, clear wins and the write is dropped.
  - pix_we = 1 (without clear): bit row[pix_y][pix_x] <= pix_val.
  - start = 1: go to SCAN; rom_addr <= 0; accumulator <= 0; busy <= 1.
    - A pix_we or clear in the same cycle as start is still committed, and the scan sees it.
- State SCAN (16 cycles, one per row):
  - On each edge, accumulator <= accumulator + popcount(row[rom_addr] XOR rom_row). The popcount is 5 bits wide (0..16).
  - If rom_addr < 15: rom_addr increments.
  - If rom_addr = 15:
    - distance <= accumulator + popcount(row 15 XOR rom_row);
    - match <= (that value <= THRESHOLD);
    - done <= 1 for exactly one cycle;
    - busy <= 0; rom_addr <= 0; state <= IDLE.
  - While in SCAN, start, pix_we and clear are ignored and the bitmap is frozen.
- Latency: start sampled at edge E0 → done high during the cycle after edge E16 (16 cycles); busy high for exactly 16 cycles.
- Back-to-back scans: start may be high in the same cycle as done, because the block is already in IDLE then. Accepting that start does not disturb the distance/match values just reported.
- distance and match hold their values until the next scan completes.
- Arithmetic: the accumulator is 9 bits and cannot overflow (maximum 256). The comparison is unsigned.

Decomposition:
- Shared package constants:
  - GLYPH_W = 16, GLYPH_H = 16, ADDR_W = 4, DIST_W = 9;
  - state encoding IDLE = 1'b0, SCAN = 1'b1.
- One natural sub-module: popcount16, purely combinational, 16-bit input to 5-bit count. It is reusable by other recognition blocks.

Test Plan:
All scenarios use the '+' template: 3-pixel vertical bar at x = 6..8 in rows 0-5 and 9-15, full-width rows 6-8; 87 ones in total.
1. Write the exact '+' via pix_we, then start → done 16 cycles after start; distance = 0, match = 1; busy high for exactly 16 cycles; rom_addr sequences 0..15.
2. Reset, leave the bitmap empty, start → distance = 87, match = 0.
3. Write all 256 pixels = 1, start → distance = 169, match = 0.
4. '+' with 24 pixels flipped → distance = 24, match = 1. Then flip one more pixel and rescan → distance = 25, match = 0 (boundary at THRESHOLD).
5. Pulse start, then during the scan assert start, pix_we (x = 0, y = 0, val = 1) and clear → none takes effect; the result matches scenario 1; bitmap pixel (0,0) is still 0 afterwards.
6. Deassert rst_n at cycle 8 of a scan → busy, done, distance, match and rom_addr go to 0 immediately; no done pulse; bitmap is cleared; a following scan of an empty bitmap gives 87.
